// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_pkg
//  Purpose  : Shared definitions for the seven-segment scan driver.
//             Holds the active-low hex glyph table ({g,f,e,d,c,b,a}), the
//             all-unlit pattern and a counter-width helper.
//  Revision : 1.0  initial release
// ============================================================================
package ssd_pkg;

  // Active-low glyphs: a 0 bit lights the segment.
  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  localparam logic [6:0] SEG_BLANK_AL = 7'b1111111;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_glyph_rom.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_glyph_rom
//  Purpose  : Combinational hex nibble to active-low seven-segment glyph.
//  Ports    : nibble_i [3:0]  hex digit
//             glyph_o  [6:0]  {g,f,e,d,c,b,a}, 0 = segment lit
//  Revision : 1.0  initial release
// ============================================================================
module ssd_glyph_rom
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = SEG_BLANK_AL;
    case (nibble_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = GLYPH_A;
      4'hB: glyph_o = GLYPH_B;
      4'hC: glyph_o = GLYPH_C;
      4'hD: glyph_o = GLYPH_D;
      4'hE: glyph_o = GLYPH_E;
      4'hF: glyph_o = GLYPH_F;
      default: glyph_o = SEG_BLANK_AL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : ssd_scan_driver
//  Purpose  : Time-multiplexed hex driver for multi-digit seven-segment
//             displays. New data is captured into a shadow register and only
//             committed to the display at a frame wrap, so frames never tear.
//  Ports    : clk, rst (sync, active high)
//             load        capture value/blank_mask/dp_in into the shadow
//             value       4*NUM_DIGITS hex nibbles, digit 0 = LS nibble
//             blank_mask  per-digit blank
//             dp_in       per-digit decimal point
//             pending     shadow holds data not yet shown
//             seg, dp     segment outputs (polarity per SEG_ACTIVE_LOW)
//             an          digit selects (polarity per AN_ACTIVE_LOW)
//  Options  : `define SSD_SCAN_LEADING_ZERO_BLANK_EN to blank leading zero
//             digits at commit time.
//  Revision : 1.0  initial release
// ============================================================================
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    pending,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned DIV_W = cnt_width(REFRESH_DIV);
  localparam int unsigned IDX_W = cnt_width(NUM_DIGITS);

  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF  = SEG_ACTIVE_LOW ? SEG_BLANK_AL : ~SEG_BLANK_AL;
  localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;

  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] sh_value_q, sh_value_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_value_q, disp_value_d;
  logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    tick, wrap, commit;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [4*NUM_DIGITS-1:0] eff_value;
  logic [NUM_DIGITS-1:0]   eff_blank, eff_dp;
  logic [3:0]              sel_nibble;
  logic                    sel_blank, sel_dp;
  logic [6:0]              glyph_al;
  logic [NUM_DIGITS-1:0]   onehot;

  // Leading-zero suppression works on the shadow, since that is what a
  // commit copies into the display registers.
`ifdef SSD_SCAN_LEADING_ZERO_BLANK_EN
  logic lz_run;
  always_comb begin
    lz_mask = '0;
    lz_run  = 1'b1;
    // Digit 0 is excluded so an all-zero value still shows a single 0.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lz_run && (sh_value_q[4*i +: 4] == 4'h0) && !sh_dp_q[i]) begin
        lz_mask[i] = 1'b1;
      end else begin
        lz_run = 1'b0;
      end
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    tick   = (div_q == DIV_LAST);
    wrap   = tick && (idx_q == IDX_LAST);
    commit = wrap && pending_q;

    div_d = tick ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    // Shadow: last load wins. A load on a commit edge refills the shadow
    // after the old contents have been copied, so pending remains set.
    sh_value_d = sh_value_q;
    sh_blank_d = sh_blank_q;
    sh_dp_d    = sh_dp_q;
    pending_d  = pending_q;
    if (commit) begin
      pending_d = 1'b0;
    end
    if (load) begin
      sh_value_d = value;
      sh_blank_d = blank_mask;
      sh_dp_d    = dp_in;
      pending_d  = 1'b1;
    end

    disp_value_d = disp_value_q;
    disp_blank_d = disp_blank_q;
    disp_dp_d    = disp_dp_q;
    if (commit) begin
      disp_value_d = sh_value_q;
      disp_blank_d = sh_blank_q | lz_mask;
      disp_dp_d    = sh_dp_q;
    end

    // Digit 0 of a committing frame must already show the new data, so the
    // output stage looks at the next-state display contents.
    eff_value = disp_value_d;
    eff_blank = disp_blank_d;
    eff_dp    = disp_dp_d;

    sel_nibble = 4'h0;
    sel_blank  = 1'b1;
    sel_dp     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        sel_nibble = eff_value[4*i +: 4];
        sel_blank  = eff_blank[i];
        sel_dp     = eff_dp[i];
      end
    end
  end

  ssd_glyph_rom u_glyph_rom (
    .nibble_i (sel_nibble),
    .glyph_o  (glyph_al)
  );

  always_comb begin
    onehot = NUM_DIGITS'(1) << idx_d;
    an_d   = an_q;
    seg_d  = seg_q;
    dp_d   = dp_q;
    if (tick) begin
      if (sel_blank) begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = DP_OFF;
      end else begin
        an_d  = AN_ACTIVE_LOW ? ~onehot : onehot;
        seg_d = SEG_ACTIVE_LOW ? glyph_al : ~glyph_al;
        dp_d  = sel_dp ? ~DP_OFF : DP_OFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= IDX_LAST;
      pending_q    <= 1'b0;
      sh_value_q   <= '0;
      sh_blank_q   <= '1;
      sh_dp_q      <= '0;
      disp_value_q <= '0;
      disp_blank_q <= '1;
      disp_dp_q    <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      sh_value_q   <= sh_value_d;
      sh_blank_q   <= sh_blank_d;
      sh_dp_q      <= sh_dp_d;
      disp_value_q <= disp_value_d;
      disp_blank_q <= disp_blank_d;
      disp_dp_q    <= disp_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign pending = pending_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign an      = an_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ssd_scan_driver
//  Purpose  : Directed self-checking bench for ssd_scan_driver
//             (NUM_DIGITS=4, REFRESH_DIV=4, active-low segments and anodes).
//             p counts rising edges after reset release; outputs are sampled
//             1 time unit after an edge and inputs are changed right after.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ssd_scan_driver;

  localparam logic [6:0] G_0 = 7'b1000000;
  localparam logic [6:0] G_1 = 7'b1111001;
  localparam logic [6:0] G_2 = 7'b0100100;
  localparam logic [6:0] G_3 = 7'b0110000;
  localparam logic [6:0] G_4 = 7'b0011001;
  localparam logic [6:0] G_5 = 7'b0010010;
  localparam logic [6:0] G_6 = 7'b0000010;
  localparam logic [6:0] G_8 = 7'b0000000;
  localparam logic [6:0] G_A = 7'b0001000;
  localparam logic [6:0] G_C = 7'b1000110;
  localparam logic [6:0] G_D = 7'b0100001;
  localparam logic [6:0] G_F = 7'b0001110;
  localparam logic [6:0] OFF = 7'b1111111;

`ifdef SSD_SCAN_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        pending;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int p = 0;
  int checks = 0;
  int errors = 0;

  ssd_scan_driver #(
    .NUM_DIGITS     (4),
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blank_mask (blank_mask),
    .dp_in      (dp_in),
    .pending    (pending),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  always #5 clk = ~clk;

  task automatic go(input int target);
    repeat (target - p) @(posedge clk);
    p = target;
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                     input logic e_dp, input logic e_pend);
    checks++;
    assert ({pending, an, seg, dp} === {e_pend, e_an, e_seg, e_dp}) else begin
      errors++;
      $error("FAIL %s @p=%0d: observed pend=%b an=%b seg=%b dp=%b, expected pend=%b an=%b seg=%b dp=%b",
             tag, p, pending, an, seg, dp, e_pend, e_an, e_seg, e_dp);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
    value      = v;
    blank_mask = b;
    dp_in      = d;
    load       = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 4'b1111, OFF, 1'b1, 1'b0);
    rst = 1'b0;

    // 1: no load, display stays dark through the first wrap (p=4).
    for (int i = 1; i <= 8; i++) begin
      go(i);
      chk("idle_dark", 4'b1111, OFF, 1'b1, 1'b0);
    end

    // 2: load 1234; wraps occur at p=4,20,36,52,...
    do_load(16'h1234, 4'b0000, 4'b0000);
    go(9);  load = 1'b0;
    chk("pend_set", 4'b1111, OFF, 1'b1, 1'b1);
    go(19); chk("pend_hold", 4'b1111, OFF, 1'b1, 1'b1);
    go(20); chk("f1_d0", 4'b1110, G_4, 1'b1, 1'b0);
    go(23); chk("f1_d0_hold", 4'b1110, G_4, 1'b1, 1'b0);
    go(24); chk("f1_d1", 4'b1101, G_3, 1'b1, 1'b0);
    go(28); chk("f1_d2", 4'b1011, G_2, 1'b1, 1'b0);
    go(32); chk("f1_d3", 4'b0111, G_1, 1'b1, 1'b0);
    go(36); chk("f2_d0", 4'b1110, G_4, 1'b1, 1'b0);

    // 3a: load ABCD while digit 1 is showing.
    go(41); do_load(16'hABCD, 4'b0000, 4'b0000);
    go(42); load = 1'b0;
    chk("abcd_pend", 4'b1101, G_3, 1'b1, 1'b1);
    go(44); chk("abcd_old_d2", 4'b1011, G_2, 1'b1, 1'b1);
    go(48); chk("abcd_old_d3", 4'b0111, G_1, 1'b1, 1'b1);
    go(52); chk("abcd_d0", 4'b1110, G_D, 1'b1, 1'b0);
    go(56); chk("abcd_d1", 4'b1101, G_C, 1'b1, 1'b0);

    // 3b: two loads in one frame, last wins.
    do_load(16'h1111, 4'b0000, 4'b0000);
    go(57); load = 1'b0;
    go(60); do_load(16'h2222, 4'b0000, 4'b0000);
    go(61); load = 1'b0;
    go(64); chk("abcd_d3", 4'b0111, G_A, 1'b1, 1'b1);
    go(68); chk("two_d0", 4'b1110, G_2, 1'b1, 1'b0);
    go(72); chk("two_d1", 4'b1101, G_2, 1'b1, 1'b0);
    go(76); chk("two_d2", 4'b1011, G_2, 1'b1, 1'b0);
    go(80); chk("two_d3", 4'b0111, G_2, 1'b1, 1'b0);

    // 4: blank digit 3, dp on digit 0.
    do_load(16'h8888, 4'b1000, 4'b0001);
    go(81); load = 1'b0;
    go(84); chk("bl_d0_dp", 4'b1110, G_8, 1'b0, 1'b0);
    go(88); chk("bl_d1", 4'b1101, G_8, 1'b1, 1'b0);
    go(92); chk("bl_d2", 4'b1011, G_8, 1'b1, 1'b0);
    go(96); chk("bl_d3_dark", 4'b1111, OFF, 1'b1, 1'b0);
    go(99); chk("bl_d3_hold", 4'b1111, OFF, 1'b1, 1'b0);
    go(100); chk("bl_d0_again", 4'b1110, G_8, 1'b0, 1'b0);

    // 5: load coincident with the wrap at p=116.
    do_load(16'h5555, 4'b0000, 4'b0000);
    go(101); load = 1'b0;
    go(115); do_load(16'h6666, 4'b0000, 4'b0000);
    go(116); load = 1'b0;
    chk("coinc_old", 4'b1110, G_5, 1'b1, 1'b1);
    go(120); chk("coinc_old_d1", 4'b1101, G_5, 1'b1, 1'b1);
    go(132); chk("coinc_new", 4'b1110, G_6, 1'b1, 1'b0);

    // 5b: reset mid-frame with a pending load.
    go(133); do_load(16'h7777, 4'b0000, 4'b0000);
    go(134); load = 1'b0;
    chk("pre_rst", 4'b1110, G_6, 1'b1, 1'b1);
    rst = 1'b1;
    go(135); chk("mid_rst", 4'b1111, OFF, 1'b1, 1'b0);
    rst = 1'b0;
    // First tick after release at p=139 is a wrap; pending load was dropped.
    go(139); chk("post_rst_wrap", 4'b1111, OFF, 1'b1, 1'b0);

    // 6: leading zeros; wraps at p=155,171,187,203.
    do_load(16'h00F0, 4'b0000, 4'b0000);
    go(140); load = 1'b0;
    go(155); chk("lz_f0_d0", 4'b1110, G_0, 1'b1, 1'b0);
    go(159); chk("lz_f0_d1", 4'b1101, G_F, 1'b1, 1'b0);
    go(163); chk("lz_f0_d2", LZ ? 4'b1111 : 4'b1011, LZ ? OFF : G_0, 1'b1, 1'b0);
    go(167); chk("lz_f0_d3", LZ ? 4'b1111 : 4'b0111, LZ ? OFF : G_0, 1'b1, 1'b0);

    do_load(16'h0000, 4'b0000, 4'b0000);
    go(168); load = 1'b0;
    go(171); chk("lz_00_d0", 4'b1110, G_0, 1'b1, 1'b0);
    go(175); chk("lz_00_d1", LZ ? 4'b1111 : 4'b1101, LZ ? OFF : G_0, 1'b1, 1'b0);
    go(179); chk("lz_00_d2", LZ ? 4'b1111 : 4'b1011, LZ ? OFF : G_0, 1'b1, 1'b0);
    go(183); chk("lz_00_d3", LZ ? 4'b1111 : 4'b0111, LZ ? OFF : G_0, 1'b1, 1'b0);

    do_load(16'h0000, 4'b0000, 4'b0100);
    go(184); load = 1'b0;
    go(187); chk("lz_dp_d0", 4'b1110, G_0, 1'b1, 1'b0);
    go(191); chk("lz_dp_d1", 4'b1101, G_0, 1'b1, 1'b0);
    go(195); chk("lz_dp_d2", 4'b1011, G_0, 1'b0, 1'b0);
    go(199); chk("lz_dp_d3", LZ ? 4'b1111 : 4'b0111, LZ ? OFF : G_0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
Parametrised, time-multiplexed hex display driver for common-segment multi-digit seven-segment modules.
- Holds a NUM_DIGITS-nibble value with per-digit blank and decimal-point masks.
- Scans one digit at a time at a programmable refresh rate.
- Applies new data only at frame boundaries, so the display never tears.
- Sits between user logic (counters, register readback) and board display pins. Successor to the single-digit hex-to-segment decoder.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; must be ≥1.
- REFRESH_DIV, 50000: clock cycles each digit is held; must be ≥1.
- SEG_ACTIVE_LOW, 1: 1 = seg/dp driven low to light; 0 = high to light.
- AN_ACTIVE_LOW, 1: 1 = an bit low selects digit; 0 = high selects.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  single-cycle request to capture value/blank_mask/dp_in
- value  in  4*NUM_DIGITS  hex nibbles; nibble i ([4i+3:4i]) drives digit i; digit 0 = least significant
- blank_mask  in  NUM_DIGITS  bit i = 1 blanks digit i
- dp_in  in  NUM_DIGITS  bit i = 1 lights the decimal point of digit i
- pending  out  1  captured data not yet committed to the display
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
- an  out  NUM_DIGITS  digit select, one-hot active, polarity per AN_ACTIVE_LOW

Behaviour:
Reset (sampled on clk edge while rst=1):
- Divider = 0; scan_idx = NUM_DIGITS-1; pending = 0.
- Shadow and display registers: value 0, blank all ones, dp 0.
- Outputs: an all inactive, seg all unlit, dp unlit.
- A reset asserted mid-frame takes effect at the next edge; any pending load is discarded.

Divider and scan:
- Divider counts 0..REFRESH_DIV-1 and wraps. The terminal count is the "tick".
- On tick, scan_idx advances modulo NUM_DIGITS.
- The first tick after reset therefore selects digit 0.

Frame wrap:
- A tick that moves scan_idx from NUM_DIGITS-1 to 0 is a frame wrap.
- With NUM_DIGITS=1, every tick is a frame wrap.

Outputs:
- seg, dp and an are registered and change only on the tick edge, all together, reflecting the new scan_idx.
- Each digit is held exactly REFRESH_DIV cycles; frame period = NUM_DIGITS*REFRESH_DIV cycles.

Glyphs (active-low form, {g..a}):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Inverted when SEG_ACTIVE_LOW=0.

Blanked digit:
- During its slot, an stays all inactive and seg/dp are unlit.
- Slot timing is unchanged.

Load handshake:
- load=1 captures value, blank_mask and dp_in into the shadow registers and sets pending=1 on the next edge.
- A load while pending overwrites the shadow; last load wins.
- At a frame wrap with pending=1: display registers ← shadow and pending ← 0. Digit 0 of the new frame uses the new data on that same edge.
- Load coincident with a frame-wrap commit: the commit uses the old shadow, the shadow takes the new data, and pending stays 1.
- load is never back-pressured.

Optional Feature:
Macro: SSD_SCAN_LEADING_ZERO_BLANK_EN
- Defined: at commit, contiguous zero nibbles from digit NUM_DIGITS-1 downward are additionally blanked, stopping at the first nonzero nibble. Digit 0 is never suppressed. A digit is not suppressed if its dp bit is set, and suppression stops at that digit.
- Undefined: zeros are displayed; only blank_mask blanks.

Decomposition:
- Package ssd_pkg holds:
  - the 16 glyph constants (active-low form);
  - SEG_BLANK_AL = 7'b1111111;
  - a function returning the divider width, $clog2 with a minimum of 1.
- One sub-module, ssd_glyph_rom: combinational nibble → active-low glyph. It is instantiated once on the scan-selected nibble; polarity inversion is done in the parent.

Test Plan:
Bench configuration: NUM_DIGITS=4, REFRESH_DIV=4, active-low defaults.
1. Reset released, no load → an=1111, seg=1111111, dp=1 every cycle; pending=0.
2. load with value=16'h1234, blank_mask=0 → pending=1 until the next wrap. Then:
   - an sequence 1110, 1101, 1011, 0111, each held 4 cycles, period 16;
   - seg = 0011001, 0110000, 0100100, 1111001 respectively;
   - pending=0.
3. Mid-frame loads:
   - load 16'hABCD while an=1101 → digits 2 and 3 still show 2 and 1; digit 0 of the next frame shows d=0100001.
   - Loads of 16'h1111 then 16'h2222 within one frame → only 2 is ever displayed.
4. blank_mask=4'b1000, dp_in=4'b0001, value=16'h8888 → digit 3 slot: an=1111. Digit 0 slot: dp=0, seg=0000000.
5. Load coincident with a frame-wrap tick → the old shadow is committed and pending stays 1; the new data is committed at the following wrap. Separately, rst pulsed mid-frame → all outputs inactive next cycle, pending=0.
6. With SSD_SCAN_LEADING_ZERO_BLANK_EN defined:
   - value=16'h00F0 → digits 3 and 2 dark; digit 1 = 0001110; digit 0 = 1000000.
   - value=16'h0000 → only digit 0 lit with 0.
   - value=16'h0000 with dp_in=4'b0100 → digits 2, 1 and 0 lit.
   - With the macro undefined, value=16'h00F0 → all four digits lit.
